// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional parity, stop bit.
// Good words are handed off through a one-deep valid/ready holding register.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_ok_q, par_ok_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    // True when data bits plus the received parity bit match the configured sense.
    function automatic logic parity_ok(input logic [DATA_W-1:0] data, input logic par_bit);
        return (((^data) ^ par_bit) == ODD_BIT);
    endfunction

    // Next-state, datapath and frame outcome decision.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        dout_d       = dout_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!din) begin
                    state_d  = S_DATA;
                    cnt_d    = '0;
                    shift_d  = '0;
                    par_ok_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                shift_d[cnt_q] = din;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                par_ok_d = parity_ok(shift_q, din);
                state_d  = S_STOP;
            end
            S_STOP: begin
                // Outcome priority: framing, then parity, then holding-register overrun.
                state_d = S_IDLE;
                if (!din) begin
                    frame_err_d = 1'b1;
                end else if (!par_ok_q) begin
                    parity_err_d = 1'b1;
                end else if (dout_valid_q && !dout_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    dout_d       = shift_q;
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default, no-parity and odd-parity instances.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       din_a, din_b, din_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       val_a, val_b, val_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic       busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fails  = 0;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .dout(dout_a), .dout_valid(val_a),
        .dout_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .dout(dout_b), .dout_valid(val_b),
        .dout_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .reset(reset), .din(din_c), .dout(dout_c), .dout_valid(val_c),
        .dout_ready(rdy_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame word, bit 0 sent first: start, data LSB-first, [parity], stop.
    function automatic logic [31:0] mkf(input logic [7:0] d, input logic p, input logic s, input bit pen);
        if (pen) return {21'd0, s, p, d, 1'b0};
        else     return {22'd0, s, d, 1'b0};
    endfunction

    task automatic send(input int sel, input logic [31:0] bits, input int n,
                        input bit rdy_at_stop, input bit chk_busy);
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       din_a = bits[i];
                1:       din_b = bits[i];
                default: din_c = bits[i];
            endcase
            if (rdy_at_stop && i == n - 1) rdy_a = 1'b1;
            tick();
            if (chk_busy && i < n - 1) check("busy_in_frame", {15'd0, busy_a}, 16'd1);
        end
        if (rdy_at_stop) rdy_a = 1'b0;
        din_a = 1'b1;
        din_b = 1'b1;
        din_c = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic consume_a();
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        din_a = 1'b1; din_b = 1'b1; din_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_dout",  {8'd0, dout_a}, 16'h0000);
        check("rst_valid", {15'd0, val_a}, 16'd0);
        check("rst_errs",  {13'd0, perr_a, ferr_a, ovr_a}, 16'd0);
        check("rst_busy",  {15'd0, busy_a}, 16'd0);

        // Single good frame 0xA5
        send(0, mkf(8'hA5, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b1);
        check("good_dout",  {8'd0, dout_a}, 16'h00A5);
        check("good_valid", {15'd0, val_a}, 16'd1);
        check("good_errs",  {13'd0, perr_a, ferr_a, ovr_a}, 16'd0);
        check("good_busy_end", {15'd0, busy_a}, 16'd0);
        tick();
        check("good_valid_hold", {15'd0, val_a}, 16'd1);
        consume_a();
        check("good_consumed", {15'd0, val_a}, 16'd0);
        check("good_dout_kept", {8'd0, dout_a}, 16'h00A5);

        // Parity error on 0xA5
        do_reset();
        send(0, mkf(8'hA5, 1'b1, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("perr_pulse", {15'd0, perr_a}, 16'd1);
        check("perr_no_ferr", {15'd0, ferr_a}, 16'd0);
        check("perr_valid", {15'd0, val_a}, 16'd0);
        check("perr_dout",  {8'd0, dout_a}, 16'h0000);
        tick();
        check("perr_one_cycle", {15'd0, perr_a}, 16'd0);

        // Framing error on 0x3C, then 0x81 received
        send(0, mkf(8'h3C, 1'b0, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        check("ferr_pulse", {15'd0, ferr_a}, 16'd1);
        check("ferr_no_perr", {15'd0, perr_a}, 16'd0);
        check("ferr_valid", {15'd0, val_a}, 16'd0);
        tick();
        check("ferr_one_cycle", {15'd0, ferr_a}, 16'd0);
        send(0, mkf(8'h81, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("after_ferr_dout",  {8'd0, dout_a}, 16'h0081);
        check("after_ferr_valid", {15'd0, val_a}, 16'd1);
        consume_a();

        // Overrun: 0x12 held, 0x34 back-to-back
        send(0, mkf(8'h12, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("ovr_first_dout", {8'd0, dout_a}, 16'h0012);
        send(0, mkf(8'h34, 1'b1, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("ovr_pulse", {15'd0, ovr_a}, 16'd1);
        check("ovr_dout_kept", {8'd0, dout_a}, 16'h0012);
        check("ovr_valid", {15'd0, val_a}, 16'd1);
        check("ovr_no_other_err", {14'd0, perr_a, ferr_a}, 16'd0);
        tick();
        check("ovr_one_cycle", {15'd0, ovr_a}, 16'd0);
        consume_a();
        check("ovr_consumed", {15'd0, val_a}, 16'd0);
        check("ovr_dout_after", {8'd0, dout_a}, 16'h0012);

        // Simultaneous consume and load
        send(0, mkf(8'h55, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("sim_first", {8'd0, dout_a}, 16'h0055);
        send(0, mkf(8'hAA, 1'b0, 1'b1, 1'b1), 11, 1'b1, 1'b0);
        check("sim_dout", {8'd0, dout_a}, 16'h00AA);
        check("sim_valid", {15'd0, val_a}, 16'd1);
        check("sim_no_ovr", {15'd0, ovr_a}, 16'd0);
        consume_a();

        // Reset mid-frame after 4 data bits, then 0xF0
        send(0, mkf(8'hF0, 1'b0, 1'b1, 1'b1), 5, 1'b0, 1'b0);
        check("mid_busy", {15'd0, busy_a}, 16'd1);
        do_reset();
        check("mid_rst_outs", {dout_a, 3'd0, val_a, perr_a, ferr_a, ovr_a, busy_a}, 16'h0000);
        send(0, mkf(8'hF0, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("mid_f0_dout",  {8'd0, dout_a}, 16'h00F0);
        check("mid_f0_valid", {15'd0, val_a}, 16'd1);

        // No-parity instance: mid-frame reset then 10-bit 0x0F
        send(1, mkf(8'h0F, 1'b0, 1'b1, 1'b0), 5, 1'b0, 1'b0);
        check("np_mid_busy", {15'd0, busy_b}, 16'd1);
        do_reset();
        check("np_rst_outs", {dout_b, 3'd0, val_b, perr_b, ferr_b, ovr_b, busy_b}, 16'h0000);
        send(1, mkf(8'h0F, 1'b0, 1'b1, 1'b0), 10, 1'b0, 1'b0);
        check("np_dout",  {8'd0, dout_b}, 16'h000F);
        check("np_valid", {15'd0, val_b}, 16'd1);
        check("np_errs",  {13'd0, perr_b, ferr_b, ovr_b}, 16'd0);

        // Odd-parity instance: 0x0F needs parity 1; parity 0 is rejected
        send(2, mkf(8'h0F, 1'b1, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("odd_dout",  {8'd0, dout_c}, 16'h000F);
        check("odd_valid", {15'd0, val_c}, 16'd1);
        check("odd_no_perr", {15'd0, perr_c}, 16'd0);
        send(2, mkf(8'h3C, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        check("odd_perr", {15'd0, perr_c}, 16'd1);
        check("odd_perr_no_ovr", {15'd0, ovr_c}, 16'd0);
        check("odd_dout_kept", {8'd0, dout_c}, 16'h000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
